controlador_interrupciones: RTL
===============================

Name: controlador_interrupciones

Overview:
Interrupt sequencer for the single-cycle CPU datapath. It edge-detects external IRQ lines, holds them pending, applies a software-written mask and fixed priority, and steps the datapath through entry and return: save PC/zero flag, force the PC to a vector, service, restore on RETI. It sits beside the unidad_control decoder. Its stall output gates we3/wez, and its s_vec/s_ret outputs override the PC source mux.

Parameters:
N_IRQ, 4, number of interrupt lines (1..8)
PC_W, 10, program counter width
VEC_BASE, 10'h3C0, address of vector 0
VEC_STRIDE, 16, address spacing between vectors

Ports:
reloj  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
irq  in  N_IRQ  external requests, level input; a rising edge is an event
instr_fin  in  1  the current instruction completes this cycle; entry is allowed only then
reti  in  1  decoded return-from-interrupt opcode, valid this cycle
mask_we  in  1  write enable for the mask register
mask_in  in  N_IRQ  new mask value (1 = line enabled)
pc_actual  in  PC_W  current PC from the datapath
zero_in  in  1  current zero flag
stall  out  1  inhibit we3 and wez this cycle
s_vec  out  1  PC mux selects vec_addr
s_ret  out  1  PC mux selects pc_ret; zero flag reloads zero_ret
vec_addr  out  PC_W  vector address of the active interrupt
pc_ret  out  PC_W  saved return PC
zero_ret  out  1  saved zero flag
irq_ack  out  N_IRQ  one-hot acknowledge pulse, one cycle
in_service  out  1  handler currently running
pending  out  N_IRQ  pending register (visible for debug)
mask_q  out  N_IRQ  current mask

Behaviour:
- Reset, sync and active-high; also applies mid-operation:
  - state=IDLE
  - pending, mask_q, irq_prev, cur_id, pc_ret and zero_ret all cleared
  - all outputs 0
  - Since irq_prev resets to 0, a line already high at reset release records one event.
- Edge detect: irq_prev <= irq every cycle. Event e[i] = irq[i] & ~irq_prev[i].
- Pending register:
  - pending[i] sets on e[i] and clears on irq_ack[i].
  - If set and clear occur in the same cycle, set wins; the new event is kept.
- Mask:
  - On mask_we, mask_q <= mask_in, in any state.
  - Same-cycle arbitration uses the old mask.
  - Masked events still become pending.
- Request: req = pending & mask_q. The winner is the lowest set index (index 0 has highest priority).
- FSM, with Moore outputs decoded from state:
  - IDLE: all control outputs 0. If |req and instr_fin, go to SAVE and, on the same edge:
    - cur_id <= winner
    - pc_ret <= pc_actual
    - zero_ret <= zero_in
    - irq_ack[winner] <= 1 as a registered one-cycle pulse
    - pending[winner] cleared
    - If |req but instr_fin=0, stay in IDLE.
  - SAVE (1 cycle): stall=1, irq_ack visible. Go to VECTOR.
  - VECTOR (1 cycle): stall=1, s_vec=1, vec_addr = VEC_BASE + cur_id*VEC_STRIDE (truncated to PC_W). Go to SERVICE.
  - SERVICE: in_service=1. There is no nesting: new events only accumulate in pending. On reti, go to RESTORE.
  - RESTORE (1 cycle): stall=1, s_ret=1, pc_ret and zero_ret are stable. Go to IDLE.
    - If req is pending, re-entry needs another instr_fin in IDLE, so at least one instruction runs between handlers.
- reti outside SERVICE is ignored.
- vec_addr, pc_ret and zero_ret hold their last values outside VECTOR/RESTORE.
- Latency: edge sampled at edge t, pending visible after t, SAVE after t+1 (when instr_fin=1), s_vec after t+2.

Decomposition:
- Package ctrl_int_pkg:
  - state enum: IDLE, SAVE, VECTOR, SERVICE, RESTORE (3-bit)
  - default VEC_BASE and VEC_STRIDE constants
  - N_IRQ upper bound
- Sub-module codificador_prioridad: parameterised on width; input req, outputs winner index and valid.

Test Plan:
1. Reset held with irq=4'b0000, then released; pulse irq[2] 0→1 with instr_fin=1, mask=4'b1111 → pending=4'b0100, then irq_ack=4'b0100 for 1 cycle; next cycle s_vec=1 with vec_addr=10'h3E0 and stall=1; then in_service=1. pc_ret equals pc_actual sampled at the entry edge.
2. In SERVICE, drive reti=1 with pc_ret=10'h07A, zero_ret=1 → s_ret=1 and stall=1 for exactly 1 cycle, then IDLE with all outputs 0.
3. Raise irq[3] and irq[1] in the same cycle → line 1 is acked first (vec 10'h3D0). After reti and RESTORE, and one instr_fin in IDLE, line 3 is acked (vec 10'h3F0).
4. mask=4'b1110, pulse irq[0] → pending[0]=1 and no entry; write mask=4'b1111 → entry starts the cycle after the write, vector 10'h3C0.
5. Hold instr_fin=0 with a request pending → FSM stays in IDLE; raise instr_fin → SAVE on that edge.
6. Assert reset during VECTOR → next cycle IDLE, all outputs 0, pending=0; reti in IDLE produces no s_ret.

Source files
------------

// File: rtl/ctrl_int_pkg.sv
// Shared types and constants for the interrupt sequencer.
//   state_t     : sequencer states (3-bit encoding)
//   IRQ_MAX     : largest supported number of interrupt lines
//   ID_W        : width of an interrupt index, sized for IRQ_MAX lines
//   VEC_BASE_D  : default address of vector 0
//   VEC_STRIDE_D: default spacing between vectors
package ctrl_int_pkg;

   localparam int IRQ_MAX      = 8;
   localparam int ID_W         = $clog2(IRQ_MAX);
   localparam int VEC_BASE_D   = 'h3C0;
   localparam int VEC_STRIDE_D = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SAVE    = 3'd1,
      VECTOR  = 3'd2,
      SERVICE = 3'd3,
      RESTORE = 3'd4
   } state_t;

endpackage

// File: rtl/codificador_prioridad.sv
// Fixed-priority encoder: the lowest set index of req wins.
//   req    in  W     request vector
//   winner out ID_W  index of the winning request (0 when none)
//   valid  out 1     at least one request is set
module codificador_prioridad
   import ctrl_int_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0]    req,
   output logic [ID_W-1:0] winner,
   output logic            valid
);

   // Scan from the top down so the last hit (lowest index) is the one kept.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (req[i]) begin
            winner = ID_W'(i);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/controlador_interrupciones.sv
// Interrupt sequencer for the single-cycle CPU datapath. Edge-detects IRQ
// lines into a pending register, masks and prioritises them, and steps the
// datapath through entry (save PC/zero, jump to vector) and RETI return.
//   reloj, reset        clock, synchronous active-high reset
//   irq                 external request levels (rising edge = event)
//   instr_fin           current instruction completes; entry only then
//   reti                return-from-interrupt decoded this cycle
//   mask_we, mask_in    mask register write
//   pc_actual, zero_in  datapath PC and zero flag to save on entry
//   stall               inhibits we3/wez
//   s_vec, vec_addr     PC mux select and target for the vector jump
//   s_ret, pc_ret,
//   zero_ret            PC mux select and saved values for the return
//   irq_ack             one-cycle one-hot acknowledge
//   in_service          handler running
//   pending, mask_q     pending and mask registers
module controlador_interrupciones
   import ctrl_int_pkg::*;
#(
   parameter int N_IRQ      = 4,
   parameter int PC_W       = 10,
   parameter int VEC_BASE   = VEC_BASE_D,
   parameter int VEC_STRIDE = VEC_STRIDE_D
) (
   input  logic             reloj,
   input  logic             reset,
   input  logic [N_IRQ-1:0] irq,
   input  logic             instr_fin,
   input  logic             reti,
   input  logic             mask_we,
   input  logic [N_IRQ-1:0] mask_in,
   input  logic [PC_W-1:0]  pc_actual,
   input  logic             zero_in,
   output logic             stall,
   output logic             s_vec,
   output logic             s_ret,
   output logic [PC_W-1:0]  vec_addr,
   output logic [PC_W-1:0]  pc_ret,
   output logic             zero_ret,
   output logic [N_IRQ-1:0] irq_ack,
   output logic             in_service,
   output logic [N_IRQ-1:0] pending,
   output logic [N_IRQ-1:0] mask_q
);

   state_t            state, state_n;
   logic [N_IRQ-1:0]  irq_prev;
   logic [N_IRQ-1:0]  evt;
   logic [N_IRQ-1:0]  req;
   logic [N_IRQ-1:0]  win_oh;
   logic [ID_W-1:0]   winner;
   logic [ID_W-1:0]   cur_id;
   logic              req_valid;
   logic              take;
   logic [PC_W-1:0]   vec_calc;

   assign evt = irq & ~irq_prev;
   // Arbitration always sees the mask as it was before any same-cycle write.
   assign req = pending & mask_q;

   codificador_prioridad #(.W(N_IRQ)) u_prio (
      .req    (req),
      .winner (winner),
      .valid  (req_valid)
   );

   assign take     = (state == IDLE) && req_valid && instr_fin;
   assign win_oh   = take ? (N_IRQ'(1) << winner) : '0;
   assign vec_calc = PC_W'(VEC_BASE + int'(winner) * VEC_STRIDE);

   // State register
   always_ff @(posedge reloj) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next state; reti is only meaningful in SERVICE
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (take) state_n = SAVE;
         SAVE:    state_n = VECTOR;
         VECTOR:  state_n = SERVICE;
         SERVICE: if (reti) state_n = RESTORE;
         RESTORE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Moore control outputs
   always_comb begin
      stall      = 1'b0;
      s_vec      = 1'b0;
      s_ret      = 1'b0;
      in_service = 1'b0;
      case (state)
         SAVE:    stall = 1'b1;
         VECTOR:  begin stall = 1'b1; s_vec = 1'b1; end
         SERVICE: in_service = 1'b1;
         RESTORE: begin stall = 1'b1; s_ret = 1'b1; end
         default: ;
      endcase
   end

   // Datapath registers. The vector address is computed from the winner at
   // the entry edge so it is already stable during VECTOR and holds after.
   always_ff @(posedge reloj) begin
      if (reset) begin
         irq_prev <= '0;
         pending  <= '0;
         mask_q   <= '0;
         cur_id   <= '0;
         pc_ret   <= '0;
         zero_ret <= 1'b0;
         vec_addr <= '0;
         irq_ack  <= '0;
      end else begin
         irq_prev <= irq;
         // A new event on the line being acked survives the clear.
         pending  <= (pending & ~win_oh) | evt;
         irq_ack  <= win_oh;
         if (mask_we) mask_q <= mask_in;
         if (take) begin
            cur_id   <= winner;
            pc_ret   <= pc_actual;
            zero_ret <= zero_in;
            vec_addr <= vec_calc;
         end
      end
   end

endmodule
